// File: rtl/alu16_sequencer.sv
// alu16_sequencer: command-driven accumulator controller for a shared 16-bit add/sub/and/or ALU
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_data - command port (LOAD/ADD/SUB/AND/OR/MUL/CLR)
//   rsp_valid/rsp_ready/rsp_data/rsp_zero/rsp_err - response port
//   alu_a/alu_b/alu_sel0/alu_sel1  - operands and select driven to the external ALU
//   alu_out                        - combinational ALU result
module alu16_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_sel0,
  output logic        alu_sel1,
  input  logic [15:0] alu_out
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MULS = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d, sel_q, sel_d;
  logic [15:0] acc_q, acc_d, opnd_q, opnd_d, prod_q, prod_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sel_d    = sel_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        // opcodes 001..100 map onto ALU selects 00..11
        sel_d  = cmd_op[1:0] - 2'd1;
        opnd_d = cmd_data;
        err_d  = cmd_op == 3'b111;
        case (cmd_op)
          3'b000: begin acc_d = cmd_data; state_d = RESP; end
          3'b110: begin acc_d = 16'h0000; state_d = RESP; end
          3'b111: state_d = RESP;
          3'b101: begin
            prod_d   = 16'h0000;
            mcand_d  = acc_q;
            mplier_d = cmd_data;
            cnt_d    = 4'd0;
            state_d  = MULS;
          end
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin acc_d = alu_out; state_d = RESP; end
      MULS: begin
        prod_d   = mplier_q[0] ? alu_out : prod_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'hf) begin acc_d = prod_d; state_d = RESP; end
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0000;
      sel_q    <= 2'b00;
      opnd_q   <= 16'h0000;
      prod_q   <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sel_q    <= sel_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
  assign cmd_ready = (state_q == IDLE) && rst_n;
  assign rsp_valid = state_q == RESP;
  assign rsp_data  = acc_q;
  assign rsp_zero  = acc_q == 16'h0000;
  assign rsp_err   = rsp_valid && err_q;
  assign alu_a     = (state_q == MULS) ? prod_q : acc_q;
  assign alu_b     = (state_q == EXEC) ? opnd_q : (state_q == MULS) ? mcand_q : 16'h0000;
  assign {alu_sel1, alu_sel0} = (state_q == EXEC) ? sel_q : 2'b00;
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: table-driven check of alu16_sequencer with a behavioural ALU
module tb_alu16_sequencer;
  logic clk = 0, rst_n = 0, cmd_valid = 0, rsp_ready = 0;
  logic [2:0] cmd_op = 0;
  logic [15:0] cmd_data = 0, alu_a, alu_b, alu_out, rsp_data;
  logic cmd_ready, rsp_valid, rsp_zero, rsp_err, alu_sel0, alu_sel1;
  int checks = 0, errors = 0;
  logic [15:0] acc_m = 0;
  typedef struct {
    logic [2:0] op;
    logic [15:0] data, exp;
    logic zero, err;
    logic [1:0] sel;
    int lat;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  assign alu_out = {alu_sel1, alu_sel0} == 2'b00 ? alu_a + alu_b :
                   {alu_sel1, alu_sel0} == 2'b01 ? alu_a - alu_b :
                   {alu_sel1, alu_sel0} == 2'b10 ? alu_a & alu_b : alu_a | alu_b;
  alu16_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .alu_a(alu_a),
    .alu_b(alu_b), .alu_sel0(alu_sel0), .alu_sel1(alu_sel1), .alu_out(alu_out)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n;
    @(negedge clk);
    cmd_valid = 1; cmd_op = v.op; cmd_data = v.data;
    check("cmd_ready idle", {31'd0, cmd_ready}, 1);
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    n = 1;
    if (v.op >= 3'd1 && v.op <= 3'd4) begin
      check("exec alu_a", {16'd0, alu_a}, {16'd0, acc_m});
      check("exec alu_b", {16'd0, alu_b}, {16'd0, v.data});
      check("exec sel", {30'd0, alu_sel1, alu_sel0}, {30'd0, v.sel});
    end
    if (v.op == 3'd5) begin
      check("mul alu_a", {16'd0, alu_a}, 0);
      check("mul alu_b", {16'd0, alu_b}, {16'd0, acc_m});
    end
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, v.lat);
    check("rsp_data", {16'd0, rsp_data}, {16'd0, v.exp});
    check("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.zero});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
    acc_m = v.exp;
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    check("rsp_valid drop", {31'd0, rsp_valid}, 0);
    check("cmd_ready back", {31'd0, cmd_ready}, 1);
  endtask
  initial begin
    int seen;
    tbl[0]  = '{3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 2'd0, 1};
    tbl[1]  = '{3'd1, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 2'd0, 2};
    tbl[2]  = '{3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'd0, 1};
    tbl[3]  = '{3'd2, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 2'd1, 2};
    tbl[4]  = '{3'd3, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 2'd2, 2};
    tbl[5]  = '{3'd4, 16'h8000, 16'h8F0F, 1'b0, 1'b0, 2'd3, 2};
    tbl[6]  = '{3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2'd0, 1};
    tbl[7]  = '{3'd1, 16'h0001, 16'h0000, 1'b1, 1'b0, 2'd0, 2};
    tbl[8]  = '{3'd0, 16'h00C8, 16'h00C8, 1'b0, 1'b0, 2'd0, 1};
    tbl[9]  = '{3'd5, 16'h0007, 16'h0578, 1'b0, 1'b0, 2'd0, 17};
    tbl[10] = '{3'd0, 16'h0100, 16'h0100, 1'b0, 1'b0, 2'd0, 1};
    tbl[11] = '{3'd5, 16'h0100, 16'h0000, 1'b1, 1'b0, 2'd0, 17};
    tbl[12] = '{3'd0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 2'd0, 1};
    tbl[13] = '{3'd7, 16'h1234, 16'h5A5A, 1'b0, 1'b1, 2'd0, 1};
    tbl[14] = '{3'd1, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 2'd0, 2};
    tbl[15] = '{3'd6, 16'h4321, 16'h0000, 1'b1, 1'b0, 2'd0, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cmd_ready", {31'd0, cmd_ready}, 0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 0);
    check("reset rsp_data", {16'd0, rsp_data}, 0);
    check("reset rsp_zero", {31'd0, rsp_zero}, 1);
    check("reset rsp_err", {31'd0, rsp_err}, 0);
    check("reset alu", {alu_a, alu_b}, 0);
    check("reset sel", {30'd0, alu_sel1, alu_sel0}, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) run(tbl[i]);
    run('{3'd0, 16'h0003, 16'h0003, 1'b0, 1'b0, 2'd0, 1});
    run('{3'd5, 16'hFFFF, 16'hFFFD, 1'b0, 1'b0, 2'd0, 17});
    run('{3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0, 2'd0, 1});
    // backpressure: response held while a command waits
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd1; cmd_data = 16'h0001;
    @(posedge clk); #1 cmd_op = 3'd0; cmd_data = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    check("bp first valid", {31'd0, rsp_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold valid", {31'd0, rsp_valid}, 1);
      check("bp hold data", {16'd0, rsp_data}, 16'h0006);
      check("bp hold cmd_ready", {31'd0, cmd_ready}, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    check("bp idle cmd_ready", {31'd0, cmd_ready}, 1);
    check("bp idle rsp_valid", {31'd0, rsp_valid}, 0);
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    check("bp next valid", {31'd0, rsp_valid}, 1);
    check("bp next data", {16'd0, rsp_data}, 16'h7777);
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    // reset in the middle of a multiply
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd5; cmd_data = 16'h0003;
    @(posedge clk); #1 cmd_valid = 0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mul busy", {31'd0, cmd_ready}, 0);
    rst_n = 0;
    @(negedge clk);
    check("rst cmd_ready", {31'd0, cmd_ready}, 0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst alu", {alu_a, alu_b}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("post rst cmd_ready", {31'd0, cmd_ready}, 1);
    check("post rst acc", {16'd0, rsp_data}, 0);
    check("post rst zero", {31'd0, rsp_zero}, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no rsp after abort", seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
